// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states,
// byte-lane enable constants and the lane/alignment helper functions.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Encoding 11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] al;
    case (size)
      SZ_HALF: al = {lo[1], 1'b0};
      SZ_WORD: al = 2'b00;
      default: al = lo;
    endcase
    return al;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE0 << lo;
      SZ_HALF: be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/half out of a RAM
// word, right-justifies it and sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    // NOTE: default assignment first so every path drives o_data and no latch is inferred.
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port word RAM. Define MISALIGN_TRAP_EN
// to reject misaligned half/word accesses; otherwise they are force-aligned.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_err
);

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_lo;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_load_data;
  logic              r_load_valid;
  logic              r_misalign_err;

  logic [1:0]  w_size;
  logic [1:0]  w_lo;
  logic        w_trap;
  logic [31:0] w_load_aligned;
  logic        w_unused_addr;

  assign w_size = norm_size(req_size);

`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_size, req_addr[1:0]);
  assign w_lo   = req_addr[1:0];
`else
  assign w_trap = 1'b0;
  assign w_lo   = align_lo(w_size, req_addr[1:0]);
`endif

  // Address bits above the RAM range are dropped so accesses wrap.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  load_align u_load_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_lo),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .o_data    (w_load_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_size         <= SZ_BYTE;
      r_signed       <= 1'b0;
      r_lo           <= 2'b00;
      r_mem_re       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_be       <= BE_NONE;
      r_mem_wdata    <= '0;
      r_load_data    <= '0;
      r_load_valid   <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_load_valid   <= 1'b0;
      r_misalign_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_size         <= w_size;
            r_signed       <= req_signed;
            r_lo           <= w_lo;
            r_mem_addr     <= req_addr[ADDR_W+1:2];
            r_mem_be       <= w_trap ? BE_NONE : lane_enable(w_size, w_lo);
            r_mem_wdata    <= replicate(w_size, req_wdata);
            r_mem_re       <= !req_we && !w_trap;
            r_mem_we       <= req_we && !w_trap;
            r_misalign_err <= w_trap;
            r_state        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Only a load that actually strobed the RAM waits for data.
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          r_mem_be <= BE_NONE;
          r_state  <= r_mem_re ? ST_RD_WAIT : ST_IDLE;
        end
        ST_RD_WAIT: begin
          r_load_data  <= w_load_aligned;
          r_load_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign mem_re       = r_mem_re;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign load_data    = r_load_data;
  assign load_valid   = r_load_valid;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-addressed reference memory predicts
// every RAM strobe, load result and trap; a negedge monitor pops and compares.
module tb_mem_access_unit;

  localparam int ADDR_W    = 10;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  typedef enum {K_LOAD, K_STORE, K_TRAP} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          acc;
  } txn_t;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       load_data;
  logic              load_valid;
  logic              misalign_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] last_load = '0;
  txn_t        exp_q[$];
  logic [31:0] ram  [MEM_WORDS];
  logic [7:0]  refb [MEM_BYTES];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (w == 0) ? 32'h8899AABB : ((32'(w) * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  // Simple synchronous RAM: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) ram[mem_addr][8*k +: 8] = mem_wdata[8*k +: 8];
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Issue one request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    txn_t e;
    int   n, ea, waits;
    bit   mis, trap;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea  = int'(a & 32'(MEM_BYTES - 1));
    mis = (ea % n) != 0;
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    ea = ea - (ea % n);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    check(req_ready == 1'b1, "accept_ready", 32'(req_ready), 32'd1);
    e.acc   = cyc;
    e.waddr = 32'(ea / 4);
    e.be    = '0;
    e.wdata = '0;
    e.data  = '0;
    if (trap) begin
      e.kind = K_TRAP;
    end else if (we) begin
      e.kind = K_STORE;
      for (int i = 0; i < n; i++) begin
        e.be[(ea % 4) + i] = 1'b1;
        refb[ea + i] = wd[8*i +: 8];
      end
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
    end else begin
      e.kind = K_LOAD;
      for (int i = 0; i < n; i++) e.data[8*i +: 8] = refb[ea + i];
      if (sg && n < 4 && e.data[8*n-1])
        for (int i = n; i < 4; i++) e.data[8*i +: 8] = 8'hFF;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor: every DUT-side event must match the head of the scoreboard.
  always @(negedge clk) begin
    txn_t e;
    bit   ok;
    if (rst_n) begin
      if (mem_re || mem_we)
        check(!(mem_re && mem_we), "strobe_exclusive", {30'd0, mem_re, mem_we}, 32'd1);
      if (mem_re) begin
        ok = exp_q.size() != 0 && exp_q[0].kind == K_LOAD;
        check(ok, "re_expected", 32'(exp_q.size()), 32'd1);
        if (ok) begin
          e = exp_q[0];
          check(32'(mem_addr) == e.waddr, "re_addr", 32'(mem_addr), e.waddr);
          check(cyc == e.acc + 1, "re_latency", 32'(cyc - e.acc), 32'd1);
        end
      end
      if (mem_we) begin
        ok = exp_q.size() != 0 && exp_q[0].kind == K_STORE;
        check(ok, "we_expected", 32'(exp_q.size()), 32'd1);
        if (ok) begin
          e = exp_q.pop_front();
          check(32'(mem_addr) == e.waddr, "we_addr", 32'(mem_addr), e.waddr);
          check(mem_be == e.be, "we_be", 32'(mem_be), 32'(e.be));
          check(mem_wdata == e.wdata, "we_wdata", mem_wdata, e.wdata);
          check(cyc == e.acc + 1, "we_latency", 32'(cyc - e.acc), 32'd1);
          check(load_data == last_load, "store_keeps_load_data", load_data, last_load);
        end
      end
      if (load_valid) begin
        ok = exp_q.size() != 0 && exp_q[0].kind == K_LOAD;
        check(ok, "load_valid_expected", 32'(exp_q.size()), 32'd1);
        if (ok) begin
          e = exp_q.pop_front();
          check(load_data == e.data, "load_data", load_data, e.data);
          check(cyc == e.acc + 3, "load_latency", 32'(cyc - e.acc), 32'd3);
          last_load = e.data;
        end
      end
      if (misalign_err) begin
        ok = exp_q.size() != 0 && exp_q[0].kind == K_TRAP;
        check(ok, "trap_expected", 32'(exp_q.size()), 32'd1);
        if (ok) begin
          e = exp_q.pop_front();
          check(cyc == e.acc + 1, "trap_latency", 32'(cyc - e.acc), 32'd1);
        end
      end
    end else begin
      last_load = '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) begin
      ram[w] = init_word(w);
      for (int b = 0; b < 4; b++) refb[4*w + b] = init_word(w) >> (8*b);
    end
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check(req_ready == 1'b1, "rst_ready", 32'(req_ready), 32'd1);
    check(mem_re == 1'b0 && mem_we == 1'b0, "rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    check(mem_be == 4'b0000, "rst_be", 32'(mem_be), 32'd0);
    check(load_data == 32'd0, "rst_load_data", load_data, 32'd0);
    check(load_valid == 1'b0 && misalign_err == 1'b0, "rst_pulses",
          {30'd0, load_valid, misalign_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Signed byte load from 0x1 of word 0x8899AABB, issued right after release.
    issue(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check(load_valid == 1'b1, "signed_byte_valid", 32'(load_valid), 32'd1);
    check(load_data == 32'hFFFFFFAA, "signed_byte_data", load_data, 32'hFFFFFFAA);

    // Half store into the upper lanes, then read the whole word back.
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check(load_data[31:16] == 16'h1234, "half_store_readback", 32'(load_data[31:16]), 32'h1234);

    // Misaligned word load: trap when enabled, otherwise word 0.
    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
`ifndef MISALIGN_TRAP_EN
    check(load_data == 32'h8899AABB, "misaligned_word_forced", load_data, 32'h8899AABB);
`endif

    // Reset while the load sits in the read-wait state.
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(load_data == 32'd0, "abort_load_data", load_data, 32'd0);
    check(load_valid == 1'b0, "abort_load_valid", 32'(load_valid), 32'd0);
    check(req_ready == 1'b1, "abort_ready", 32'(req_ready), 32'd1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check(load_data == 32'h0000_0012, "after_abort_load", load_data, 32'h0000_0012);

    // Randomized traffic, mostly back-to-back, with wrapping upper address bits.
    for (int t = 0; t < 300; t++) begin
      bit          we, sg, hold;
      logic [1:0]  sz;
      logic [31:0] a;
      we   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) != 0);
      a    = ($urandom & ~32'(MEM_BYTES - 1)) | 32'($urandom_range(0, 31));
      issue(we, sz, sg, a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;

    begin
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width presented to the data RAM.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  unit accepts request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 req_signed  input  1  sign-extend loaded byte/half.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 mem_re  output  1  RAM read strobe.
REQ-012 mem_we  output  1  RAM write strobe.
REQ-013 mem_addr  output  ADDR_W  req_addr[ADDR_W+1:2].
REQ-014 mem_be  output  4  byte-lane enables, lane k = bits [8k+7:8k].
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_rdata  input  32  RAM read data, valid the cycle after mem_re.
REQ-017 load_data  output  32  aligned, extended load result feeding the downstream 32-bit pipeline register.
REQ-018 load_valid  output  1  one-cycle pulse, load_data updated.
REQ-019 misalign_err  output  1  one-cycle pulse on rejected access (only with MISALIGN_TRAP_EN).

Function
REQ-020 FSM states IDLE, ACCESS, RD_WAIT, RESP; req_ready SHALL equal (state==IDLE).
REQ-021 IDLE & req_valid: latch request, go ACCESS; else stay IDLE.
REQ-022 ACCESS: mem_re/mem_we, mem_addr, mem_be, mem_wdata driven from registered request; store -> IDLE, load -> RD_WAIT.
REQ-023 RD_WAIT: sample mem_rdata, align and extend into load_data, go RESP.
REQ-024 RESP: load_valid=1 for exactly this cycle, go IDLE.
REQ-025 Load latency: accepted cycle N -> mem_re at N+1 -> load_valid at N+3; req_ready again at N+4. Store: mem_we at N+1, req_ready at N+2.
REQ-026 Lane select little-endian: byte lane = addr[1:0]; half lanes {addr[1],0} pair; word all lanes.
REQ-027 mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-028 Load extract: selected lane(s) shifted to bits [7:0]/[15:0]; upper bits = sign bit if req_signed else 0; word loads unmodified.
REQ-029 load_data SHALL hold its value between loads; stores never change load_data or pulse load_valid.
REQ-030 mem_re and mem_we SHALL never be high together and only in ACCESS.
REQ-031 req_addr bits above ADDR_W+1 ignored (address wraps modulo RAM size).

Reset
REQ-032 rst_n low: state=IDLE, mem_re=mem_we=0, mem_be=0, load_data=0, load_valid=0, misalign_err=0, immediately and asynchronously.
REQ-033 Reset during ACCESS/RD_WAIT/RESP aborts the access; no load_valid issued after release.
REQ-034 First request accepted the first rising edge after rst_n deasserts.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no RAM strobe, misalign_err pulse in ACCESS, return IDLE, load_valid not asserted.
REQ-036 Macro absent: misalign_err tied 0; misaligned addresses force-aligned (low bits cleared per size) and executed normally.

Structure
REQ-037 Shared package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane-enable constants.
REQ-038 Sub-module load_align (combinational extract + extension from rdata, addr[1:0], size, signed) instantiated once.

Verification
REQ-039 RAM word 0 = 0x8899AABB; load byte signed addr 0x1 -> load_data 0xFFFFFFAA, load_valid 3 cycles after accept.
REQ-040 Store half 0x1234 addr 0x6 -> mem_be 1100, mem_wdata 0x12341234; then load word addr 0x4 -> upper half 0x1234.
REQ-041 Back-to-back req_valid held high: loads accepted every 4 cycles, stores every 2, no lost or duplicate requests.
REQ-042 rst_n low while in RD_WAIT -> load_data 0, no load_valid pulse, next request completes normally.
REQ-043 Word load addr 0x2: with MISALIGN_TRAP_EN misalign_err pulse, no mem_re; without, word at 0x0 returned.
